// File: rtl/ethernet_tx_arbiter_pkg.sv
// Shared packet-type codes, FSM state type and one-hot helpers for the Ethernet TX arbiter.
package ethernet_tx_arbiter_pkg;

  localparam logic [2:0] PktArpReply  = 3'd1;
  localparam logic [2:0] PktIcmpReply = 3'd2;
  localparam logic [2:0] PktArpReq    = 3'd3;
  localparam logic [2:0] PktUdp       = 3'd4;

  typedef enum logic [2:0] {StIdle, StStart, StWait, StSend, StGap} state_e;

  function automatic logic [2:0] pktType(input logic [3:0] oh);
    logic [2:0] t;
    unique case (oh)
      4'b0001: t = PktArpReply;
      4'b0010: t = PktIcmpReply;
      4'b0100: t = PktArpReq;
      default: t = PktUdp;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] ohIndex(input logic [3:0] oh);
    logic [1:0] idx;
    unique case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/eth_tx_pick.sv
// Combinational one-hot request picker; search begins at startIdx and wraps upward.
module eth_tx_pick (
  input  logic [3:0] req,
  input  logic [1:0] startIdx,
  output logic [3:0] pick
);

  logic [1:0] idx;

  // Walk from the farthest candidate back to startIdx so the nearest one wins.
  always_comb begin
    pick = 4'b0000;
    idx  = startIdx;
    for (int k = 3; k >= 0; k--) begin
      idx = startIdx + 2'(k);
      if (req[idx]) begin
        pick = 4'b0001 << idx;
      end
    end
  end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// Shares EthernetTX between ARP reply, ICMP reply, ARP request and UDP sources.
// Define ETH_TX_RR_EN for round-robin arbitration; fixed priority otherwise.
module ethernet_tx_arbiter
  import ethernet_tx_arbiter_pkg::*;
#(
  parameter int unsigned IFG_CYCLES    = 192,
  parameter int unsigned ARP_DATA_LEN  = 18,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic       clk20,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [9:0] icmp_len,
  input  logic [9:0] udp_len,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic       busy,
  output logic       tx_err,
  output logic       SendStart,
  output logic [2:0] SendPacketType,
  output logic [9:0] SendDataLen,
  input  logic       SendingPacket
);

  state_e     stateQ, stateD;
  logic [7:0] cntQ, cntD;
  logic [3:0] grantQ, grantD;
  logic [3:0] doneQ, doneD;
  logic       errQ, errD;
  logic       startQ, startD;
  logic [2:0] typeQ, typeD;
  logic [9:0] lenQ, lenD;
  logic [1:0] startIdx;
  logic [3:0] pick;

`ifdef ETH_TX_RR_EN
  logic [1:0] ptrQ, ptrD;
  assign startIdx = ptrQ + 2'd1;
`else
  assign startIdx = 2'd0;
`endif

  eth_tx_pick u_pick (
    .req      (req),
    .startIdx (startIdx),
    .pick     (pick)
  );

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    grantD = grantQ;
    doneD  = 4'b0000;
    errD   = 1'b0;
    startD = 1'b0;
    typeD  = typeQ;
    lenD   = lenQ;
`ifdef ETH_TX_RR_EN
    ptrD   = ptrQ;
`endif
    unique case (stateQ)
      StIdle: begin
        // A stray frame still in EthernetTX holds off arbitration.
        if (|req && !SendingPacket) begin
          grantD = pick;
          typeD  = pktType(pick);
          lenD   = pick[1] ? icmp_len : (pick[3] ? udp_len : 10'(ARP_DATA_LEN));
          stateD = StStart;
`ifdef ETH_TX_RR_EN
          ptrD   = ohIndex(pick);
`endif
        end
      end
      StStart: begin
        startD = 1'b1;
        cntD   = 8'd0;
        stateD = StWait;
      end
      StWait: begin
        if (SendingPacket) begin
          stateD = StSend;
        end else if (cntQ == 8'(START_TIMEOUT - 1)) begin
          errD   = 1'b1;
          doneD  = grantQ;
          grantD = 4'b0000;
          cntD   = 8'd0;
          stateD = StGap;
        end else begin
          cntD = cntQ + 8'd1;
        end
      end
      StSend: begin
        if (!SendingPacket) begin
          doneD  = grantQ;
          grantD = 4'b0000;
          cntD   = 8'd0;
          stateD = StGap;
        end
      end
      StGap: begin
        if (cntQ == 8'(IFG_CYCLES - 1)) begin
          stateD = StIdle;
        end else begin
          cntD = cntQ + 8'd1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk20) begin
    if (rst) begin
      stateQ <= StIdle;
      cntQ   <= 8'd0;
      grantQ <= 4'b0000;
      doneQ  <= 4'b0000;
      errQ   <= 1'b0;
      startQ <= 1'b0;
      typeQ  <= PktUdp;
      lenQ   <= 10'd0;
`ifdef ETH_TX_RR_EN
      ptrQ   <= 2'd3;
`endif
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      grantQ <= grantD;
      doneQ  <= doneD;
      errQ   <= errD;
      startQ <= startD;
      typeQ  <= typeD;
      lenQ   <= lenD;
`ifdef ETH_TX_RR_EN
      ptrQ   <= ptrD;
`endif
    end
  end

  assign grant          = grantQ;
  assign done           = doneQ;
  assign busy           = (stateQ != StIdle);
  assign tx_err         = errQ;
  assign SendStart      = startQ;
  assign SendPacketType = typeQ;
  assign SendDataLen    = lenQ;

endmodule
